// File: rtl/router_1xn_if.sv
// Packet-router bus bundle.
// Purpose : groups the byte-stream source side and the per-channel consumer
//           side of router_1xn into one interface.
// Signals : pkt_valid/data_in/busy  - source byte stream with hold request
//           rd_en/data_out/vld_out  - per-channel FWFT FIFO read side
//           err/drop/soft_rst       - parity error, dropped packet, timeout flush
// Modports: master = traffic source and consumers, slave = router.
interface router_1xn_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned NCH = 3
);
    logic              pkt_valid;
    logic [DW-1:0]     data_in;
    logic [NCH-1:0]    rd_en;
    logic [NCH*DW-1:0] data_out;
    logic [NCH-1:0]    vld_out;
    logic              busy;
    logic              err;
    logic              drop;
    logic [NCH-1:0]    soft_rst;

    modport master (
        output pkt_valid, data_in, rd_en,
        input  data_out, vld_out, busy, err, drop, soft_rst
    );

    modport slave (
        input  pkt_valid, data_in, rd_en,
        output data_out, vld_out, busy, err, drop, soft_rst
    );
endinterface

// File: rtl/router_1xn.sv
// Parametrised 1-to-N packet router.
// Purpose : decodes header (addr = low AW bits, len = upper bits), writes the
//           packet into the addressed first-word-fall-through FIFO, checks
//           XOR parity, drops packets to non-existent channels and flushes a
//           channel whose consumer leaves valid data unread for TIMEOUT cycles.
// Ports   : clk  - clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - router_1xn_if.slave (byte stream in, NCH channels out)
module router_1xn #(
    parameter int unsigned DW         = 8,
    parameter int unsigned NCH        = 3,
    parameter int unsigned AW         = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 30
) (
    input  logic       clk,
    input  logic       rst,
    router_1xn_if.slave bus
);
    localparam int unsigned LW    = DW - AW;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    localparam int unsigned NSLOT = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DROP
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]     addr_q;
    logic [LW-1:0]     len_q;
    logic [DW-1:0]     par_q;
    logic              err_q;
    logic              drop_q;

    logic [AW-1:0]     hdr_addr;
    logic              hdr_ok;
    logic [NCH-1:0]    full;
    logic [NSLOT-1:0]  full_ext;
    logic [NCH-1:0]    vld_vec;
    logic [NCH-1:0]    soft_rst_q;
    logic [NCH*DW-1:0] dout_vec;
    logic              busy_c;
    logic              accept;

    logic              push;
    logic [AW-1:0]     push_addr;
    logic              latch_hdr;
    logic              clr_err;
    logic              chk_par;
    logic              cnt_dec;
    logic              upd_par;
    logic              drop_set;

    // Header decode; unused address slots read as never-full so indexing is safe.
    assign hdr_addr = bus.data_in[AW-1:0];
    assign hdr_ok   = 32'(hdr_addr) < NCH;
    assign full_ext = NSLOT'(full);

    // Hold request: only raised when the byte would have to land in a full FIFO.
    always_comb begin
        busy_c = 1'b0;
        case (state)
            S_LOAD:  busy_c = full_ext[addr_q];
            S_IDLE:  busy_c = bus.pkt_valid && hdr_ok && full_ext[hdr_addr];
            default: busy_c = 1'b0;
        endcase
    end

    assign accept = bus.pkt_valid && !busy_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath controls.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_addr = addr_q;
        latch_hdr = 1'b0;
        clr_err   = 1'b0;
        chk_par   = 1'b0;
        cnt_dec   = 1'b0;
        upd_par   = 1'b0;
        drop_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    latch_hdr = 1'b1;
                    if (hdr_ok) begin
                        push      = 1'b1;
                        push_addr = hdr_addr;
                        clr_err   = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_DROP;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    push    = 1'b1;
                    upd_par = 1'b1;
                    // Remaining count zero means this byte is the parity byte.
                    if (len_q == '0) begin
                        chk_par   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (accept) begin
                    if (len_q == '0) begin
                        drop_set  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Packet bookkeeping: address, remaining length, running parity, status.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            par_q  <= '0;
            err_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_set;
            if (latch_hdr) begin
                addr_q <= hdr_addr;
                len_q  <= bus.data_in[DW-1:AW];
                par_q  <= bus.data_in;
            end else begin
                if (cnt_dec) len_q <= len_q - LW'(1);
                if (upd_par) par_q <= par_q ^ bus.data_in;
            end
            // par_q still excludes the parity byte when it is compared.
            if (clr_err) begin
                err_q <= 1'b0;
            end else if (chk_par) begin
                err_q <= (par_q != bus.data_in);
            end
        end
    end

    // Per-channel FWFT FIFO with stall-timeout flush.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DW-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [CW-1:0] cnt;
        logic [TW-1:0] to_cnt;
        logic [TW-1:0] to_nxt;
        logic          soft_q;
        logic          vld;
        logic          do_push;
        logic          do_pop;

        assign vld     = cnt != '0;
        assign full[k] = cnt == CW'(FIFO_DEPTH);
        // A flush in progress swallows both the push and the pop of that edge.
        assign do_push = push && (32'(push_addr) == k) && !soft_q;
        assign do_pop  = bus.rd_en[k] && vld && !soft_q;

        assign vld_vec[k]               = vld;
        assign soft_rst_q[k]            = soft_q;
        assign dout_vec[k*DW +: DW]     = vld ? mem[rd_ptr] : '0;

        always_ff @(posedge clk) begin
            if (do_push) mem[wr_ptr] <= bus.data_in;
        end

        always_ff @(posedge clk) begin
            if (rst || soft_q) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
                cnt <= cnt + CW'(do_push) - CW'(do_pop);
            end
        end

        // Stall counter; soft_q marks the cycle it reaches TIMEOUT, flush follows.
        always_comb begin
            to_nxt = to_cnt + TW'(1);
            if (soft_q || bus.rd_en[k] || !vld) to_nxt = '0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                to_cnt <= '0;
                soft_q <= 1'b0;
            end else begin
                to_cnt <= to_nxt;
                soft_q <= (to_nxt == TW'(TIMEOUT));
            end
        end
    end

    assign bus.data_out = dout_vec;
    assign bus.vld_out  = vld_vec;
    assign bus.busy     = busy_c;
    assign bus.err      = err_q;
    assign bus.drop     = drop_q;
    assign bus.soft_rst = soft_rst_q;

endmodule

// File: tb/tb_router_1xn.sv
// Directed self-checking bench for router_1xn (DW=8, NCH=3, AW=2, depth 16, timeout 30).
module tb_router_1xn;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    router_1xn_if #(.DW(8), .NCH(3)) bus ();

    router_1xn #(
        .DW(8), .NCH(3), .AW(2), .FIFO_DEPTH(16), .TIMEOUT(30)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        bus.pkt_valid = 1'b1;
        bus.data_in   = b;
        #1;
        while (bus.busy && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) chk("send_bound", 64'(g), 64'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] head(input int k);
        logic [23:0] d;
        d = bus.data_out;
        return d[k*8 +: 8];
    endfunction

    logic [7:0] exp4 [22];
    logic [7:0] exp_rd [4];
    int ri;
    int si;
    int guard;

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.data_in   = 8'h00;
        bus.rd_en     = 3'b000;
        tick();
        tick();
        chk("rst_vld", 64'(bus.vld_out), 64'(0));
        chk("rst_data", 64'(bus.data_out), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        chk("rst_drop", 64'(bus.drop), 64'(0));
        chk("rst_soft", 64'(bus.soft_rst), 64'(0));
        rst = 1'b0;
        tick();

        // Basic routing to channel 1.
        send_byte(8'h09);
        chk("t1_hdr_vld", 64'(bus.vld_out), 64'(3'b010));
        chk("t1_hdr_data", 64'(head(1)), 64'(8'h09));
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h3A);
        bus.pkt_valid = 1'b0;
        chk("t1_err", 64'(bus.err), 64'(0));
        chk("t1_vld", 64'(bus.vld_out), 64'(3'b010));
        exp_rd[0] = 8'h09; exp_rd[1] = 8'h11; exp_rd[2] = 8'h22; exp_rd[3] = 8'h3A;
        bus.rd_en = 3'b010;
        for (int i = 0; i < 4; i++) begin
            chk("t1_pop_vld", 64'(bus.vld_out[1]), 64'(1));
            chk("t1_pop_data", 64'(head(1)), 64'(exp_rd[i]));
            tick();
        end
        bus.rd_en = 3'b000;
        chk("t1_empty", 64'(bus.vld_out), 64'(0));

        // Parity error on channel 2: 06^5A = 5C, parity byte sent as 00.
        send_byte(8'h06);
        send_byte(8'h5A);
        send_byte(8'h00);
        bus.pkt_valid = 1'b0;
        chk("t2_err", 64'(bus.err), 64'(1));
        chk("t2_vld", 64'(bus.vld_out), 64'(3'b100));
        exp_rd[0] = 8'h06; exp_rd[1] = 8'h5A; exp_rd[2] = 8'h00;
        bus.rd_en = 3'b100;
        for (int i = 0; i < 3; i++) begin
            chk("t2_pop_data", 64'(head(2)), 64'(exp_rd[i]));
            tick();
        end
        bus.rd_en = 3'b000;
        chk("t2_empty", 64'(bus.vld_out), 64'(0));
        chk("t2_err_hold", 64'(bus.err), 64'(1));

        // Invalid address 3: consumed silently, drop pulses once.
        send_byte(8'h07);
        chk("t3_busy0", 64'(bus.busy), 64'(0));
        chk("t3_vld0", 64'(bus.vld_out), 64'(0));
        send_byte(8'hAA);
        chk("t3_drop_early", 64'(bus.drop), 64'(0));
        send_byte(8'hAD);
        bus.pkt_valid = 1'b0;
        chk("t3_drop", 64'(bus.drop), 64'(1));
        chk("t3_vld1", 64'(bus.vld_out), 64'(0));
        chk("t3_err", 64'(bus.err), 64'(1));
        tick();
        chk("t3_drop_end", 64'(bus.drop), 64'(0));

        // FIFO full / back-pressure: len 20 to ch0, parity 50^14 = 44.
        exp4[0] = 8'h50;
        for (int i = 1; i <= 20; i++) exp4[i] = 8'(i);
        exp4[21] = 8'h44;
        for (int i = 0; i < 16; i++) send_byte(exp4[i]);
        chk("t4_err_clr", 64'(bus.err), 64'(0));
        bus.pkt_valid = 1'b1;
        bus.data_in   = exp4[16];
        #1;
        chk("t4_busy", 64'(bus.busy), 64'(1));
        tick();
        tick();
        chk("t4_busy_hold", 64'(bus.busy), 64'(1));
        chk("t4_head", 64'(head(0)), 64'(8'h50));
        bus.rd_en = 3'b001;
        #1;
        chk("t4_busy_prepop", 64'(bus.busy), 64'(1));
        tick();
        chk("t4_busy_rel", 64'(bus.busy), 64'(0));
        ri = 1;
        si = 16;
        guard = 0;
        while (ri < 22 && guard < 100) begin
            if (si < 22) begin
                bus.pkt_valid = 1'b1;
                bus.data_in   = exp4[si];
            end else begin
                bus.pkt_valid = 1'b0;
            end
            #1;
            if (bus.vld_out[0]) begin
                chk("t4_data", 64'(head(0)), 64'(exp4[ri]));
                ri++;
            end
            if (bus.pkt_valid && !bus.busy) si++;
            tick();
            guard++;
        end
        bus.pkt_valid = 1'b0;
        bus.rd_en     = 3'b000;
        chk("t4_read_cnt", 64'(ri), 64'(22));
        chk("t4_err", 64'(bus.err), 64'(0));
        chk("t4_empty", 64'(bus.vld_out), 64'(0));

        // Timeout flush: 30 unread cycles then soft_rst, empty next cycle.
        send_byte(8'h00);
        send_byte(8'h00);
        bus.pkt_valid = 1'b0;
        for (int i = 0; i < 28; i++) tick();
        chk("t5_soft_pre", 64'(bus.soft_rst), 64'(0));
        chk("t5_vld_pre", 64'(bus.vld_out), 64'(3'b001));
        tick();
        chk("t5_soft", 64'(bus.soft_rst), 64'(3'b001));
        chk("t5_vld_soft", 64'(bus.vld_out), 64'(3'b001));
        tick();
        chk("t5_soft_end", 64'(bus.soft_rst), 64'(0));
        chk("t5_flushed", 64'(bus.vld_out), 64'(0));

        // Read at cycle 29 restarts the count: 04 (len1 addr0), 33, parity 37.
        send_byte(8'h04);
        send_byte(8'h33);
        send_byte(8'h37);
        bus.pkt_valid = 1'b0;
        for (int i = 0; i < 26; i++) tick();
        bus.rd_en = 3'b001;
        tick();
        bus.rd_en = 3'b000;
        chk("t5b_soft0", 64'(bus.soft_rst), 64'(0));
        chk("t5b_head", 64'(head(0)), 64'(8'h33));
        for (int i = 0; i < 29; i++) tick();
        chk("t5b_soft_pre", 64'(bus.soft_rst), 64'(0));
        chk("t5b_vld_pre", 64'(bus.vld_out), 64'(3'b001));
        tick();
        chk("t5b_soft", 64'(bus.soft_rst), 64'(3'b001));
        tick();
        chk("t5b_flushed", 64'(bus.vld_out), 64'(0));

        // Reset mid-packet, then a clean packet to ch1: 05, A0, A5.
        send_byte(8'h0D);
        send_byte(8'h01);
        send_byte(8'h02);
        bus.pkt_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("t6_rst_vld", 64'(bus.vld_out), 64'(0));
        chk("t6_rst_data", 64'(bus.data_out), 64'(0));
        chk("t6_rst_busy", 64'(bus.busy), 64'(0));
        chk("t6_rst_err", 64'(bus.err), 64'(0));
        chk("t6_rst_drop", 64'(bus.drop), 64'(0));
        chk("t6_rst_soft", 64'(bus.soft_rst), 64'(0));
        rst = 1'b0;
        tick();
        send_byte(8'h05);
        send_byte(8'hA0);
        send_byte(8'hA5);
        bus.pkt_valid = 1'b0;
        chk("t6_vld", 64'(bus.vld_out), 64'(3'b010));
        chk("t6_err", 64'(bus.err), 64'(0));
        exp_rd[0] = 8'h05; exp_rd[1] = 8'hA0; exp_rd[2] = 8'hA5;
        bus.rd_en = 3'b010;
        for (int i = 0; i < 3; i++) begin
            chk("t6_pop_data", 64'(head(1)), 64'(exp_rd[i]));
            tick();
        end
        bus.rd_en = 3'b000;
        chk("t6_empty", 64'(bus.vld_out), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_1xn.md
Name: router_1xn

Overview:
- Parametrised 1-to-N packet router, successor to the fixed 1x3 router.
- Accepts a byte stream of header + payload + parity and decodes the destination from the header.
- Writes each packet into the selected per-channel FIFO and checks XOR parity.
- Drops packets with an invalid address and flushes channels whose consumer stalls past a timeout.

Parameters:
DW, 8, data/byte width in bits.
NCH, 3, number of output channels (2..2**AW).
AW, 2, header address field width; NCH <= 2**AW.
FIFO_DEPTH, 16, entries per channel FIFO (power of 2).
TIMEOUT, 30, cycles of unread valid data before a channel soft reset.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
pkt_valid  in  1  data_in qualifier.
data_in  in  DW  header/payload/parity byte.
rd_en  in  NCH  per-channel pop request.
data_out  out  NCH*DW  channel k head entry at bits [k*DW +: DW].
vld_out  out  NCH  channel k FIFO non-empty.
busy  out  1  source must hold the current byte; byte not accepted.
err  out  1  parity mismatch on the last completed packet.
drop  out  1  one-cycle pulse when an invalid-address packet finishes.
soft_rst  out  NCH  one-cycle pulse when channel k is flushed by timeout.

Behaviour:
- Reset (rst=1 at an edge): FSM goes to IDLE; all FIFOs empty; all counters 0.
- Reset values: vld_out=0, data_out=0, busy=0, err=0, drop=0, soft_rst=0.
- Reset mid-packet discards the packet in flight and all FIFO contents.
- Acceptance: a byte is accepted on an edge where pkt_valid=1 and busy=0.
- Header format: addr=data_in[AW-1:0], len=data_in[DW-1:AW] (payload bytes, 0 legal). Packet = 1 header + len payload + 1 parity byte.
- Packet end is determined by the length count only; pkt_valid low between bytes only stalls.
- FSM IDLE: on an accepted byte, latch addr and len, and set the running parity to that byte.
  - addr<NCH: push the header to FIFO[addr]; go to LOAD; clear err.
  - addr>=NCH: go to DROP.
- FSM LOAD: push each accepted byte to FIFO[addr] and XOR it into the running parity.
  - The byte accepted with remaining count 0 is the parity byte; it is pushed too.
  - At that same edge, err <= (running parity != byte); go to IDLE.
- FSM DROP: consume len+1 further bytes with no push.
  - drop pulses the cycle after the last byte; go to IDLE; err unchanged.
- busy is combinational and equals 1 when either:
  - LOAD and FIFO[addr] full, or
  - IDLE and pkt_valid and data_in addr<NCH and that FIFO is full.
  - DROP never asserts busy.
- FIFO full is evaluated before the same-cycle pop; push while full never occurs.
- FIFOs are first-word-fall-through:
  - vld_out[k]=count[k]!=0; data_out slice is the head entry, combinational.
  - rd_en[k]=1 with vld_out[k]=1 pops at the edge; rd_en on an empty FIFO is ignored.
  - Push and pop in the same cycle leave the count unchanged.
- Latency: header visible on vld_out/data_out the cycle after acceptance.
- Pointers wrap modulo FIFO_DEPTH; count spans 0..FIFO_DEPTH.
- Timeout: per-channel counter increments each cycle vld_out[k]=1 and rd_en[k]=0.
  - Counter clears on rd_en[k]=1 or empty.
  - Reaching TIMEOUT flushes FIFO k at the next edge, pulses soft_rst[k], and clears the counter.
- Flush during LOAD to the same channel: stored entries are discarded; the remaining bytes of the packet are still written.
- Flush and push in the same cycle: flush wins, the push is lost, and the packet continues.

Test Plan:
- Basic routing: ch1, header 0x09 (len 2, addr 1), payload 0x11, 0x22, parity 0x3A, rd_en[1]=1 after end -> vld_out[1] for 4 pops, data 0x09, 0x11, 0x22, 0x3A; err=0; other channels idle.
- Parity error: ch2, header 0x06, payload 0x5A, parity 0x00 (correct 0x5C) -> err=1 after the parity edge, stays 1 until the next valid header; 3 bytes stored.
- Invalid address: header 0x07 (len 1, addr 3), bytes 0xAA, 0xAD -> no vld_out change, busy=0 throughout, drop pulses once, err unchanged.
- FIFO full and back-pressure: ch0, header 0x50 (len 20), no reads -> busy=1 with the 17th byte held; enabling rd_en[0] releases busy; all 22 bytes read in order, err=0.
- Timeout: ch0 packet stored, rd_en=0 -> soft_rst[0] pulses after 30 cycles of vld_out[0]=1; vld_out[0]=0 next cycle. A read at cycle 29 prevents the flush and restarts the count.
- Reset mid-packet: rst=1 after 2 payload bytes -> all outputs 0; a following clean packet to ch1 routes correctly.
